// File: rtl/i2s_slave_port_if.sv
// I2S link pins plus the parallel sample handshake of the slave port.
// Pure wiring; no latency.
// No backpressure: every strobe on this bundle is a single-clock pulse.
interface i2s_slave_port_if #(
    parameter int SAMPLE_BITS = 24
);
    logic                   bclk;
    logic                   lrclk;
    logic                   sdata_in;
    logic                   sdata_out;
    logic [SAMPLE_BITS-1:0] rx_left;
    logic [SAMPLE_BITS-1:0] rx_right;
    logic                   rx_valid;
    logic [SAMPLE_BITS-1:0] tx_left;
    logic [SAMPLE_BITS-1:0] tx_right;
    logic                   tx_valid;
    logic                   tx_load;
    logic                   tx_underrun;
    logic                   sync_error;

    // Codec side of the link (the design under this interface).
    modport slave (
        input  bclk, lrclk, sdata_in, tx_left, tx_right, tx_valid,
        output sdata_out, rx_left, rx_right, rx_valid, tx_load, tx_underrun, sync_error
    );

    // Bus master / sample producer side.
    modport master (
        output bclk, lrclk, sdata_in, tx_left, tx_right, tx_valid,
        input  sdata_out, rx_left, rx_right, rx_valid, tx_load, tx_underrun, sync_error
    );
endinterface

// File: rtl/i2s_slave_port.sv
// I2S (Philips) slave endpoint: oversamples BCLK/LRCLK, deserializes DOUT, serializes DIN.
// Latency: pin edges act 3 clocks later; rx_valid 4 clocks after the LRCLK edge ending a right slot.
// No backpressure: tx pairs are latest-wins into a pending register; rx pairs are pulsed, not held off.
module i2s_slave_port #(
    parameter int SAMPLE_BITS = 24,
    parameter int SLOT_BITS   = 32
) (
    input  logic           clock,
    input  logic           nreset,
    i2s_slave_port_if.slave bus
);
    localparam logic [5:0] SLOT_LAST = 6'(SLOT_BITS - 1);
    localparam logic [6:0] SB7       = 7'(SAMPLE_BITS);

    // [0],[1] are the synchronizer stages, [2] is the history flop for edge detection.
    logic [2:0] bclk_sync, lr_sync;
    logic [1:0] sd_sync;
    logic [1:0] prime;
    logic       primed;
    logic       bclk_rise, bclk_fall, lr_evt, lr_frame, sd_bit;

    logic [5:0] bit_cnt;
    logic       first_rise;
    logic       in_slot;
    logic       slot_ok;

    logic [SAMPLE_BITS-1:0] rx_shift, left_hold, rx_left_r, rx_right_r;
    logic                   left_ok, pair_done, rx_valid_r, sync_error_r;

    logic [SAMPLE_BITS-1:0] pend_l, pend_r, tx_shift_l, tx_shift_r;
    logic                   pend_vld, tx_chan_r, tx_load_r, tx_underrun_r, sdata_out_r;
    logic [6:0]             tx_cnt;

    // Edge events are gated until the sync pipeline has been refilled after reset,
    // so a pin already high at release does not look like a transition.
    assign primed    = (prime == 2'd3);
    assign bclk_rise = primed &&  bclk_sync[1] && !bclk_sync[2];
    assign bclk_fall = primed && !bclk_sync[1] &&  bclk_sync[2];
    assign lr_evt    = primed && (lr_sync[1] != lr_sync[2]);
    assign lr_frame  = lr_evt && !lr_sync[1];
    assign sd_bit    = sd_sync[1];
    // Completed slot must have started on a seen transition and contained exactly SLOT_BITS rises.
    assign slot_ok   = in_slot && !first_rise && (bit_cnt == SLOT_LAST);

    // Two-flop synchronizers plus history flops for edge detection.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            prime     <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], bus.bclk};
            lr_sync   <= {lr_sync[1:0], bus.lrclk};
            sd_sync   <= {sd_sync[0], bus.sdata_in};
            if (!primed) prime <= prime + 2'd1;
        end
    end

    // Per-slot bclk-rise counter: position 0 is the first rise after a transition, saturates at 63.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            bit_cnt    <= '0;
            first_rise <= 1'b1;
            in_slot    <= 1'b0;
        end else if (lr_evt) begin
            first_rise <= 1'b1;
            in_slot    <= 1'b1;
        end else if (bclk_rise) begin
            if (first_rise) begin
                bit_cnt    <= '0;
                first_rise <= 1'b0;
            end else if (bit_cnt != 6'd63) begin
                bit_cnt <= bit_cnt + 6'd1;
            end
        end
    end

    // Receive: shift positions 1..SAMPLE_BITS, pair up left/right at slot ends, drop bad slots.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rx_shift     <= '0;
            left_hold    <= '0;
            left_ok      <= 1'b0;
            rx_left_r    <= '0;
            rx_right_r   <= '0;
            pair_done    <= 1'b0;
            rx_valid_r   <= 1'b0;
            sync_error_r <= 1'b0;
        end else begin
            pair_done    <= 1'b0;
            rx_valid_r   <= pair_done;
            sync_error_r <= lr_evt && in_slot && !slot_ok;
            if (lr_evt) begin
                rx_shift <= '0;
                if (!lr_sync[2]) begin
                    left_hold <= rx_shift;
                    left_ok   <= slot_ok;
                end else begin
                    left_ok <= 1'b0;
                    if (slot_ok && left_ok) begin
                        rx_left_r  <= left_hold;
                        rx_right_r <= rx_shift;
                        pair_done  <= 1'b1;
                    end
                end
            end else if (bclk_rise && !first_rise && ({1'b0, bit_cnt} < SB7)) begin
                rx_shift <= {rx_shift[SAMPLE_BITS-2:0], sd_bit};
            end
        end
    end

    // Transmit: latest-wins pending pair, commit at frame start, MSB-first shift on bclk fall.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pend_l        <= '0;
            pend_r        <= '0;
            pend_vld      <= 1'b0;
            tx_shift_l    <= '0;
            tx_shift_r    <= '0;
            tx_chan_r     <= 1'b0;
            tx_cnt        <= '0;
            tx_load_r     <= 1'b0;
            tx_underrun_r <= 1'b0;
            sdata_out_r   <= 1'b0;
        end else begin
            tx_load_r <= 1'b0;
            if (bus.tx_valid && !lr_frame) begin
                pend_l   <= bus.tx_left;
                pend_r   <= bus.tx_right;
                pend_vld <= 1'b1;
            end
            if (lr_evt) begin
                tx_cnt    <= '0;
                tx_chan_r <= lr_sync[1];
                if (lr_frame) begin
                    tx_load_r <= 1'b1;
                    pend_vld  <= 1'b0;
                    if (bus.tx_valid) begin
                        tx_shift_l <= bus.tx_left;
                        tx_shift_r <= bus.tx_right;
                    end else if (pend_vld) begin
                        tx_shift_l <= pend_l;
                        tx_shift_r <= pend_r;
                    end else begin
                        tx_shift_l    <= '0;
                        tx_shift_r    <= '0;
                        tx_underrun_r <= 1'b1;
                    end
                end
            end else if (bclk_fall) begin
                if (tx_cnt < SB7) begin
                    tx_cnt <= tx_cnt + 7'd1;
                    if (tx_chan_r) begin
                        sdata_out_r <= tx_shift_r[SAMPLE_BITS-1];
                        tx_shift_r  <= {tx_shift_r[SAMPLE_BITS-2:0], 1'b0};
                    end else begin
                        sdata_out_r <= tx_shift_l[SAMPLE_BITS-1];
                        tx_shift_l  <= {tx_shift_l[SAMPLE_BITS-2:0], 1'b0};
                    end
                end else begin
                    sdata_out_r <= 1'b0;
                end
            end
        end
    end

    assign bus.sdata_out   = sdata_out_r;
    assign bus.rx_left     = rx_left_r;
    assign bus.rx_right    = rx_right_r;
    assign bus.rx_valid    = rx_valid_r;
    assign bus.tx_load     = tx_load_r;
    assign bus.tx_underrun = tx_underrun_r;
    assign bus.sync_error  = sync_error_r;
endmodule

// File: doc/i2s_slave_port.md
Name: i2s_slave_port

Overview:
- I2S slave endpoint, the far end of the transceiver's I2S master bus; it plays the codec/MCU side.
- It takes BCLK and LRCLK from the master, oversamples them on the local system clock, deserializes stereo samples from DOUT, and serializes stereo samples onto DIN.
- Uses: loopback/pattern test harness for the I2S link on RF boards, and a synthesizable codec model for board-level benches.

Parameters:
- SAMPLE_BITS, 24, width of each channel sample, MSB-first, left-justified in the slot.
- SLOT_BITS, 32, BCLK periods per channel slot; must be >= SAMPLE_BITS.

Ports:
- clock  in  1  system clock; must be >= 4x BCLK frequency.
- nreset  in  1  asynchronous active-low reset.
- bclk  in  1  I2S bit clock from master; asynchronous to clock.
- lrclk  in  1  I2S word select from master (0 = left, 1 = right).
- sdata_in  in  1  serial data from master (master DOUT).
- sdata_out  out  1  serial data to master (master DIN).
- rx_left  out  SAMPLE_BITS  last received left sample.
- rx_right  out  SAMPLE_BITS  last received right sample.
- rx_valid  out  1  one-clock pulse: rx_left/rx_right updated as a pair.
- tx_left  in  SAMPLE_BITS  left sample to send.
- tx_right  in  SAMPLE_BITS  right sample to send.
- tx_valid  in  1  one-clock pulse: tx_left/tx_right pair offered.
- tx_load  out  1  one-clock pulse: pending pair committed to the shifter for the coming frame.
- tx_underrun  out  1  sticky: a frame started with no new pair since the last load; cleared by reset only.
- sync_error  out  1  one-clock pulse: slot length != SLOT_BITS.

Behaviour:
- Input sync: bclk, lrclk and sdata_in each pass through two flops. Edges are detected from the synced bclk (rise/fall) and synced lrclk. Internal edge events lag the pin edge by 3 clocks.
- Reset: all outputs 0. Shifters, bit counter and pending registers are cleared. pending_valid = 0.
- Framing: I2S Philips.
  - An LRCLK transition marks a slot boundary.
  - The sample MSB sits in the 2nd BCLK period after the transition (1-bit delay).
  - An LRCLK 1->0 transition starts a frame, i.e. a left slot.
- Bit counter: 6-bit.
  - Cleared on the first bclk rise after an LRCLK transition.
  - Incremented on every later bclk rise in the slot.
  - Saturates at 63.
- Receive: bits are captured on synced bclk rise.
  - Bit positions 1..SAMPLE_BITS of a slot shift into rx_shift (MSB first).
  - Position 0 holds the previous slot's LSB per I2S and is ignored for this slot.
  - Positions beyond SAMPLE_BITS are ignored.
- Receive slot end: detected at the next LRCLK transition.
  - Left slot: rx_shift goes to a left holding register.
  - Right slot: rx_left <= left holding and rx_right <= rx_shift on the same clock; rx_valid pulses on the next clock.
  - Latency: rx_valid asserts 4 clocks after the LRCLK pin edge that ends the right slot.
  - rx_valid is not issued for a frame whose left slot was never seen after reset.
- Transmit handshake:
  - tx_valid pulse loads tx_left/tx_right into pending registers and sets pending_valid.
  - A later tx_valid before the next commit overwrites the pending pair (latest wins).
- Transmit commit: on the synced LRCLK 1->0 event.
  - pending_valid = 1: the pair goes to tx_shift_l/tx_shift_r, pending_valid is cleared, tx_load pulses once.
  - pending_valid = 0: zeros are loaded, tx_underrun is set, tx_load still pulses.
  - tx_valid on the same clock as the commit: the new pair is committed, pending_valid ends 0, no underrun.
- Transmit shift: sdata_out updates on synced bclk fall.
  - The 1st fall after a slot's LRCLK transition drives the MSB of that slot's channel.
  - Following falls drive successive bits.
  - After SAMPLE_BITS bits, sdata_out = 0 for the rest of the slot.
  - The right slot uses tx_shift_r and needs no new commit.
- Sync check: at each LRCLK transition, the completed slot's bclk-rise count is compared to SLOT_BITS.
  - Mismatch: sync_error pulses and received data for that slot is discarded (no rx_valid for that frame).
  - The first transition after reset is exempt.
- Mid-operation reset: everything returns to reset values immediately. Resync happens on the next LRCLK transition, and rx_valid needs a complete left+right pair.
- bclk idle (no edges): state holds and outputs hold; no errors are raised until an LRCLK transition occurs.

Test Plan:
- Loopback: the master sends left=0x123456, right=0xABCDEF with 32-bit slots and BCLK = clock/8. Required: rx_left=0x123456, rx_right=0xABCDEF, rx_valid one pulse per frame, 4 clocks after the right-slot-ending LRCLK edge.
- Transmit: tx_valid with left=0x800001, right=0x7FFFFE before the frame. Required: the master-side receiver decodes the same values; tx_load pulses once at the frame start; tx_underrun stays 0.
- Underrun: no tx_valid across two frames. Required: sdata_out = 0 for the whole second frame; tx_load pulses each frame; tx_underrun sets at the first starved frame and stays 1.
- Overwrite/collision: two tx_valid pulses (0x111111, then 0x222222) within one frame send 0x222222. A tx_valid on the exact commit clock is sent with no underrun.
- Short slot: the master emits a 30-BCLK left slot. Required: sync_error pulses once, no rx_valid for that frame, and the next correct frame decodes normally.
- Reset mid-slot: assert nreset during bit 10 of a right slot. Required: all outputs 0 immediately; no rx_valid until a full left+right frame follows release.
